seq_fixed_divider: RTL and testbench
====================================

Name: seq_fixed_divider

Overview:
- Parametrised multicycle unsigned fixed-point divider: Quotient = A·2^FRAC_W / D, with FRAC_W = QUOT_W − DIVIDEND_W.
- Sits beside the CPU datapath as a memory-mapped/accelerator unit, using the same Start/Ack handshake as the CPU top level.
- Generalises the 16b÷8b→24b program-2 computation to arbitrary widths.
- Adds a per-operation truncate/round-half-up mode and a divide-by-zero flag.

Parameters:
- DIVIDEND_W, 16, dividend width; must be ≥ 1.
- DIVISOR_W, 8, divisor width; must be ≥ 1.
- QUOT_W, 24, quotient width; must be ≥ DIVIDEND_W. FRAC_W = QUOT_W − DIVIDEND_W fractional bits.

Ports:
- Clk  in  1  rising-edge clock; the only clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  launch request, sampled on rising Clk.
- RoundMode  in  1  0 = truncate, 1 = half-LSB upward rounding; captured with the operands.
- Dividend  in  DIVIDEND_W  unsigned A; captured on accept.
- Divisor  in  DIVISOR_W  unsigned D; captured on accept.
- Busy  out  1  high while CALC is active.
- Ack  out  1  high while result is valid (DONE state).
- Quotient  out  QUOT_W  result; holds its value until the next accept.
- DivZero  out  1  set when the captured D = 0; valid with Ack.

Behaviour:
- Reset (asynchronous, Reset = 0, legal at any time including mid-operation):
  - State → IDLE; Busy = 0, Ack = 0, Quotient = 0, DivZero = 0; all internal registers cleared.
  - No partial result survives reset.
- States: IDLE, CALC, DONE.
- Accept:
  - Start = 1 in IDLE or DONE accepts the operation at that edge.
  - Captures A, D and RoundMode; Ack drops and DivZero clears at the same edge.
  - Start in CALC is ignored; the operation in flight completes undisturbed.
- Normal path (D ≠ 0):
  - Restoring shift-subtract over the (QUOT_W+1)-bit numerator {A, (FRAC_W+1) zeros}, MSB first, one bit per cycle.
  - Remainder register is DIVISOR_W+1 bits; the step counter is ceil(log2(QUOT_W+2)) bits.
  - Each step: R' = {R, nextbit}; if R' ≥ D then R = R' − D and qbit = 1, else R = R' and qbit = 0.
  - After QUOT_W+1 steps the raw quotient is q[QUOT_W:0]; q[0] is the guard (half-LSB) bit.
  - Quotient = q[QUOT_W:1] + (RoundMode & q[0]).
  - Overflow is impossible by construction, since A·2^FRAC_W < 2^QUOT_W; no saturation logic is required.
  - Verification asserts this bound.
- Latency:
  - Accept at edge 0; CALC runs for edges 1..QUOT_W+1.
  - DONE is entered and Ack = 1 after edge QUOT_W+2 (26 cycles at the default widths).
  - Quotient is updated at the same edge Ack rises.
- Divide by zero:
  - IDLE/DONE → DONE at the edge after accept (latency 2).
  - Quotient = all ones, DivZero = 1; CALC is skipped.
- DONE:
  - Ack is held high until a new accept or reset.
  - Start held continuously high restarts the divider every completion; the bench must drop Start.
- Busy = (state == CALC). Ack and Busy are never high together.

Decomposition:
- Shared package seq_div_pkg holds:
  - the state encoding (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2);
  - the FRAC_W and counter-width derivation functions;
  - the ROUND_TRUNC/ROUND_HALF_UP constants.
- One natural sub-module: div_step, the combinational single-iteration compare/subtract/shift returning the new remainder and qbit, so the bench can unit-test it.
- The FSM, counter and operand registers live in seq_fixed_divider.

Test Plan:
- A=0x3CAF, D=0x80, truncate → Quotient=0x00795E, DivZero=0; Ack rises exactly 26 cycles after accept.
- A=0x0002, D=0x03: truncate → 0x0000AA; round → 0x0000AB. A=0x0001, D=0x03, round → 0x000055 (guard bit 0, no increment).
- A=0xFFFF, D=0xFE, both modes → 0x010203. A=0xFFFF, D=0x01 → 0xFFFF00 (maximum reachable value, no overflow).
- A=0x1234, D=0x00 → Quotient=0xFFFFFF, DivZero=1, Ack after 2 cycles. Next accept with D=0x80 clears DivZero at the accept edge.
- Start pulsed again mid-CALC with different operands → ignored; first result delivered. Accept from DONE → Ack falls next edge and the new result follows 26 cycles later.
- Reset low at CALC step 10 → Busy/Ack/Quotient/DivZero are 0 immediately (asynchronous). After release, a fresh accept yields the correct result.
- Sweep: A = 15535..65535 step 10, D = 128..254, both modes, checked against a model floor(A·2^(FRAC_W+1)/D), with the guard bit added when rounding. Repeat with QUOT_W=32, DIVIDEND_W=16, DIVISOR_W=12.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential fixed-point divider.
//   state_e         : FSM encoding (IDLE / CALC / DONE), also exposed on the
//                     divider's dbg_state port.
//   ROUND_TRUNC     : RoundMode value selecting truncation.
//   ROUND_HALF_UP   : RoundMode value selecting half-LSB upward rounding.
//   frac_width()    : number of fractional quotient bits (QUOT_W - DIVIDEND_W).
//   count_width()   : width of the step counter, wide enough for 0..QUOT_W+1.
package seq_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic ROUND_TRUNC   = 1'b0;
   localparam logic ROUND_HALF_UP = 1'b1;

   function automatic int frac_width(input int quot_w, input int dividend_w);
      return quot_w - dividend_w;
   endfunction

   function automatic int count_width(input int quot_w);
      return $clog2(quot_w + 2);
   endfunction

endpackage

// File: rtl/seq_fixed_divider_div_step.sv
// One restoring-division iteration, purely combinational.
//   rem_in   [DIVISOR_W:0]   : partial remainder entering the step (< divisor)
//   next_bit                 : next numerator bit, MSB first
//   divisor  [DIVISOR_W-1:0] : divisor D (non-zero when used)
//   rem_out  [DIVISOR_W:0]   : partial remainder leaving the step
//   q_bit                    : quotient bit produced by this step
module div_step #(
   parameter int DIVISOR_W = 8
) (
   input  logic [DIVISOR_W:0]   rem_in,
   input  logic                 next_bit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   rem_out,
   output logic                 q_bit
);

   logic [DIVISOR_W+1:0] shifted;
   logic [DIVISOR_W:0]   diff;

   always_comb begin
      shifted = {rem_in, next_bit};
      q_bit   = (shifted >= {2'b00, divisor});
      // When the subtraction is taken the result is below D, so dropping
      // the top bit of the shifted value cannot lose information.
      diff    = shifted[DIVISOR_W:0] - {1'b0, divisor};
      rem_out = q_bit ? diff : shifted[DIVISOR_W:0];
   end

endmodule

// File: rtl/seq_fixed_divider.sv
// Multicycle unsigned fixed-point divider: Quotient = A * 2^FRAC_W / D.
// One quotient bit per cycle, with an extra guard bit used for optional
// round-half-up. Start/Ack handshake: Start is honoured in IDLE or DONE,
// ignored while busy; Ack stays high in DONE until the next accept.
//   Clk        : rising-edge clock
//   Reset      : asynchronous active-low reset
//   Start      : launch request
//   RoundMode  : 0 truncate, 1 round half-LSB up (captured on accept)
//   Dividend   : unsigned A (captured on accept)
//   Divisor    : unsigned D (captured on accept)
//   Busy       : high while the iteration runs
//   Ack        : high while the result is valid
//   Quotient   : result, updated when Ack rises
//   DivZero    : captured D was zero, valid with Ack
//   dbg_state  : current FSM state (seq_div_pkg::state_e encoding)
module seq_fixed_divider
   import seq_div_pkg::*;
#(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8,
   parameter int QUOT_W     = 24
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  RoundMode,
   input  logic [DIVIDEND_W-1:0] Dividend,
   input  logic [DIVISOR_W-1:0]  Divisor,
   output logic                  Busy,
   output logic                  Ack,
   output logic [QUOT_W-1:0]     Quotient,
   output logic                  DivZero,
   output logic [1:0]            dbg_state
);

   localparam int FRAC_W = frac_width(QUOT_W, DIVIDEND_W);
   localparam int CNT_W  = count_width(QUOT_W);

   // Iteration count QUOT_W+1 means all steps are done; that cycle
   // assembles the rounded result.
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(QUOT_W + 1);
   // A zero divisor waits two edges after accept before reporting.
   localparam logic [CNT_W-1:0] ZERO_LAST = CNT_W'(1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [QUOT_W:0]       num_q, num_d;
   logic [DIVISOR_W:0]    rem_q, rem_d;
   logic [QUOT_W:0]       qraw_q, qraw_d;
   logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
   logic                  round_q, round_d;
   logic                  zpend_q, zpend_d;
   logic [QUOT_W-1:0]     quot_q, quot_d;
   logic                  divzero_q, divzero_d;

   logic                  accept;
   logic [DIVISOR_W:0]    step_rem;
   logic                  step_bit;

   // While a divide-by-zero is pending the FSM sits in IDLE; Start is
   // ignored then so that operation also completes undisturbed.
   assign accept = Start && !zpend_q &&
                   ((state_q == ST_IDLE) || (state_q == ST_DONE));

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .rem_in   (rem_q),
      .next_bit (num_q[QUOT_W]),
      .divisor  (divisor_q),
      .rem_out  (step_rem),
      .q_bit    (step_bit)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = (Divisor == '0) ? ST_IDLE : ST_CALC;
      end else begin
         case (state_q)
            ST_IDLE: if (zpend_q && (count_q == ZERO_LAST)) state_d = ST_DONE;
            ST_CALC: if (count_q == LAST_STEP) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      Busy      = (state_q == ST_CALC);
      Ack       = (state_q == ST_DONE);
      Quotient  = quot_q;
      DivZero   = divzero_q;
      dbg_state = state_q;
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      count_d   = count_q;
      num_d     = num_q;
      rem_d     = rem_q;
      qraw_d    = qraw_q;
      divisor_d = divisor_q;
      round_d   = round_q;
      zpend_d   = zpend_q;
      quot_d    = quot_q;
      divzero_d = divzero_q;

      if (accept) begin
         // Numerator is A followed by FRAC_W result zeros plus one guard zero.
         num_d     = {Dividend, {(FRAC_W + 1){1'b0}}};
         divisor_d = Divisor;
         round_d   = RoundMode;
         rem_d     = '0;
         qraw_d    = '0;
         count_d   = '0;
         divzero_d = 1'b0;
         zpend_d   = (Divisor == '0);
      end else if ((state_q == ST_IDLE) && zpend_q) begin
         if (count_q == ZERO_LAST) begin
            zpend_d   = 1'b0;
            count_d   = '0;
            quot_d    = '1;
            divzero_d = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end else if (state_q == ST_CALC) begin
         if (count_q == LAST_STEP) begin
            // Drop the guard bit, optionally adding it back as a half-LSB
            // round. A*2^FRAC_W < 2^QUOT_W, so this sum cannot overflow.
            quot_d  = qraw_q[QUOT_W:1] +
                      {{(QUOT_W - 1){1'b0}},
                       ((round_q == ROUND_HALF_UP) & qraw_q[0])};
            count_d = '0;
         end else begin
            rem_d   = step_rem;
            qraw_d  = {qraw_q[QUOT_W-1:0], step_bit};
            num_d   = {num_q[QUOT_W-1:0], 1'b0};
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         count_q   <= '0;
         num_q     <= '0;
         rem_q     <= '0;
         qraw_q    <= '0;
         divisor_q <= '0;
         round_q   <= ROUND_TRUNC;
         zpend_q   <= 1'b0;
         quot_q    <= '0;
         divzero_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         num_q     <= num_d;
         rem_q     <= rem_d;
         qraw_q    <= qraw_d;
         divisor_q <= divisor_d;
         round_q   <= round_d;
         zpend_q   <= zpend_d;
         quot_q    <= quot_d;
         divzero_q <= divzero_d;
      end
   end

endmodule

// File: tb/tb_seq_fixed_divider.sv
// Bench for seq_fixed_divider: a default-width instance (16/8/24) and a wide
// instance (16/12/32) run concurrently, plus a standalone div_step.
// Drivers push {DivZero, Quotient} expectations; monitors pop on each Ack rise.
module tb_seq_fixed_divider;

   localparam int A_W  = 16;
   localparam int D0_W = 8;
   localparam int Q0_W = 24;
   localparam int D1_W = 12;
   localparam int Q1_W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0_n, rst1_n;

   // ---------------- DUT 0 (default widths) ----------------
   logic            start0, rm0, busy0, ack0, dz0;
   logic [A_W-1:0]  a0;
   logic [D0_W-1:0] d0;
   logic [Q0_W-1:0] q0;
   logic [1:0]      st0;

   seq_fixed_divider #(.DIVIDEND_W(A_W), .DIVISOR_W(D0_W), .QUOT_W(Q0_W)) dut0 (
      .Clk(clk), .Reset(rst0_n), .Start(start0), .RoundMode(rm0),
      .Dividend(a0), .Divisor(d0), .Busy(busy0), .Ack(ack0),
      .Quotient(q0), .DivZero(dz0), .dbg_state(st0)
   );

   // ---------------- DUT 1 (wide) ----------------
   logic            start1, rm1, busy1, ack1, dz1;
   logic [A_W-1:0]  a1;
   logic [D1_W-1:0] d1;
   logic [Q1_W-1:0] q1;
   logic [1:0]      st1;

   seq_fixed_divider #(.DIVIDEND_W(A_W), .DIVISOR_W(D1_W), .QUOT_W(Q1_W)) dut1 (
      .Clk(clk), .Reset(rst1_n), .Start(start1), .RoundMode(rm1),
      .Dividend(a1), .Divisor(d1), .Busy(busy1), .Ack(ack1),
      .Quotient(q1), .DivZero(dz1), .dbg_state(st1)
   );

   // ---------------- standalone step ----------------
   logic [D0_W:0]   su_rem_in, su_rem_out;
   logic            su_bit, su_q;
   logic [D0_W-1:0] su_d;

   div_step #(.DIVISOR_W(D0_W)) u_step_ut (
      .rem_in(su_rem_in), .next_bit(su_bit), .divisor(su_d),
      .rem_out(su_rem_out), .q_bit(su_q)
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [Q0_W:0] exp0_q[$];
   logic [Q1_W:0] exp1_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
      end
   endtask

   // Reference: the quotient with one extra fractional bit is
   // floor(A * 2^(FRAC_W+1) / D); its LSB is the guard bit.
   function automatic longint unsigned ref_div(input longint unsigned a, input longint unsigned d,
                                               input bit rm, input int frac_w, input int quot_w);
      longint unsigned raw;
      if (d == 0) return (64'd1 << quot_w) - 1;
      raw = (a << (frac_w + 1)) / d;
      return (raw >> 1) + ((rm && raw[0]) ? 64'd1 : 64'd0);
   endfunction

   task automatic bound_check(input string name, input longint unsigned v, input int quot_w);
      if (v >= (64'd1 << quot_w)) begin
         n_err++;
         $display("FAIL %s actual=%0h required=below 2^%0d", name, v, quot_w);
      end
   endtask

   // ---------------- monitors ----------------
   logic          ack0_prev = 1'b0, ack1_prev = 1'b0;
   logic [Q0_W:0] mon0_e;
   logic [Q1_W:0] mon1_e;

   always @(negedge clk) begin
      if (busy0 && ack0) begin
         n_err++;
         $display("FAIL busy_ack_overlap0 actual=both required=exclusive @%0t", $time);
      end
      if (ack0 && !ack0_prev) begin
         if (exp0_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_ack0 actual=ack required=no_ack @%0t", $time);
         end else begin
            mon0_e = exp0_q.pop_front();
            check("result0", 64'({dz0, q0}), 64'(mon0_e));
         end
      end
      ack0_prev = ack0;
   end

   always @(negedge clk) begin
      if (busy1 && ack1) begin
         n_err++;
         $display("FAIL busy_ack_overlap1 actual=both required=exclusive @%0t", $time);
      end
      if (ack1 && !ack1_prev) begin
         if (exp1_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_ack1 actual=ack required=no_ack @%0t", $time);
         end else begin
            mon1_e = exp1_q.pop_front();
            check("result1", 64'({dz1, q1}), 64'(mon1_e));
         end
      end
      ack1_prev = ack1;
   end

   // ---------------- drivers ----------------
   // Issue one operation on DUT 0 and wait for Ack. use_exp selects a
   // hand-derived expected quotient instead of the reference model;
   // glitch pulses Start with other operands in the middle of CALC.
   task automatic run0(input logic [A_W-1:0] a, input logic [D0_W-1:0] d, input logic rm,
                       input bit use_exp, input logic [Q0_W-1:0] exp_v, input bit glitch);
      longint unsigned m;
      int cyc;
      bit seen;
      m = ref_div(64'(a), 64'(d), rm, Q0_W - A_W, Q0_W);
      bound_check("bound0", m, Q0_W);
      exp0_q.push_back({(d == 0), (use_exp ? exp_v : m[Q0_W-1:0])});
      a0 = a; d0 = d; rm0 = rm; start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      check("ack_low_after_accept0", 64'(ack0), 64'd0);
      check("dz_clear_after_accept0", 64'(dz0), 64'd0);
      check("busy_after_accept0", 64'(busy0), (d != 0) ? 64'd1 : 64'd0);
      cyc = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (glitch && i == 5) begin
            a0 = ~a; d0 = d ^ 8'h3C; rm0 = ~rm; start0 = 1'b1;
         end
         if (glitch && i == 6) start0 = 1'b0;
         @(posedge clk); #1;
         cyc++;
         if (ack0) seen = 1'b1;
      end
      check("ack_seen0", 64'(seen), 64'd1);
      if (seen) check("latency0", 64'(cyc), (d == 0) ? 64'd2 : 64'(Q0_W + 2));
   endtask

   task automatic run1(input logic [A_W-1:0] a, input logic [D1_W-1:0] d, input logic rm);
      longint unsigned m;
      int cyc;
      bit seen;
      m = ref_div(64'(a), 64'(d), rm, Q1_W - A_W, Q1_W);
      bound_check("bound1", m, Q1_W);
      exp1_q.push_back({(d == 0), m[Q1_W-1:0]});
      a1 = a; d1 = d; rm1 = rm; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (ack1) seen = 1'b1;
      end
      check("ack_seen1", 64'(seen), 64'd1);
      if (seen) check("latency1", 64'(cyc), (d == 0) ? 64'd2 : 64'(Q1_W + 2));
   endtask

   task automatic seq0();
      // directed vectors
      run0(16'h3CAF, 8'h80, 1'b0, 1'b1, 24'h00795E, 1'b0);
      run0(16'h0002, 8'h03, 1'b0, 1'b1, 24'h0000AA, 1'b0);
      run0(16'h0002, 8'h03, 1'b1, 1'b1, 24'h0000AB, 1'b0);
      run0(16'h0001, 8'h03, 1'b1, 1'b1, 24'h000055, 1'b0);
      run0(16'hFFFF, 8'hFE, 1'b0, 1'b1, 24'h010203, 1'b0);
      run0(16'hFFFF, 8'hFE, 1'b1, 1'b1, 24'h010203, 1'b0);
      run0(16'hFFFF, 8'h01, 1'b1, 1'b1, 24'hFFFF00, 1'b0);
      run0(16'h1234, 8'h00, 1'b0, 1'b1, 24'hFFFFFF, 1'b0);
      run0(16'h3CAF, 8'h80, 1'b1, 1'b1, 24'h00795E, 1'b0);
      run0(16'h3CAF, 8'h80, 1'b0, 1'b1, 24'h00795E, 1'b1);
      run0(16'hFFFF, 8'h01, 1'b0, 1'b1, 24'hFFFF00, 1'b0);

      // asynchronous reset in the middle of CALC
      a0 = 16'h3CAF; d0 = 8'h80; rm0 = 1'b0; start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst0_n = 1'b0;
      #1;
      check("busy_in_reset0", 64'(busy0), 64'd0);
      check("ack_in_reset0", 64'(ack0), 64'd0);
      check("quot_in_reset0", 64'(q0), 64'd0);
      check("dz_in_reset0", 64'(dz0), 64'd0);
      check("state_in_reset0", 64'(st0), 64'd0);
      @(negedge clk);
      rst0_n = 1'b1;
      @(posedge clk); #1;
      run0(16'h0002, 8'h03, 1'b1, 1'b1, 24'h0000AB, 1'b0);

      // randomized sweep over the upper dividend range
      for (int k = 0; k < 140; k++) begin
         run0(16'($urandom_range(15535, 65535)), 8'($urandom_range(128, 254)),
              1'($urandom_range(0, 1)), 1'b0, '0, ($urandom_range(0, 9) == 0));
      end
      // full-range operands, occasional zero divisor
      for (int k = 0; k < 30; k++) begin
         run0(16'($urandom_range(0, 65535)),
              ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
              1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
      end
   endtask

   task automatic seq1();
      run1(16'hFFFF, 12'h001, 1'b1);
      run1(16'h0002, 12'h003, 1'b1);
      run1(16'h1234, 12'h000, 1'b0);
      for (int k = 0; k < 120; k++) begin
         run1(16'($urandom_range(15535, 65535)),
              ($urandom_range(0, 19) == 0) ? 12'd0 : 12'($urandom_range(128, 4095)),
              1'($urandom_range(0, 1)));
      end
   endtask

   // ---------------- main ----------------
   initial begin
      int dd, rr, bb, vv;
      rst0_n = 1'b0; rst1_n = 1'b0;
      start0 = 1'b0; rm0 = 1'b0; a0 = '0; d0 = '0;
      start1 = 1'b0; rm1 = 1'b0; a1 = '0; d1 = '0;
      su_rem_in = '0; su_bit = 1'b0; su_d = 8'd1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy0", 64'(busy0), 64'd0);
      check("reset_ack0", 64'(ack0), 64'd0);
      check("reset_quot0", 64'(q0), 64'd0);
      check("reset_dz0", 64'(dz0), 64'd0);
      check("reset_ack1", 64'(ack1), 64'd0);
      check("reset_quot1", 64'(q1), 64'd0);
      @(negedge clk);
      rst0_n = 1'b1; rst1_n = 1'b1;

      // single-iteration unit: (2R+b) split by D into quotient bit and remainder
      for (int k = 0; k < 24; k++) begin
         dd = $urandom_range(1, 255);
         rr = $urandom_range(0, dd - 1);
         bb = $urandom_range(0, 1);
         su_d = 8'(dd); su_rem_in = 9'(rr); su_bit = 1'(bb);
         #1;
         vv = 2 * rr + bb;
         check("step_qbit", 64'(su_q), 64'(vv / dd));
         check("step_rem", 64'(su_rem_out), 64'(vv % dd));
      end

      @(posedge clk); #1;
      fork
         seq0();
         seq1();
      join

      for (int i = 0; i < 60; i++) begin
         if (exp0_q.size() == 0 && exp1_q.size() == 0) break;
         @(posedge clk);
      end
      @(negedge clk);
      check("drain0", 64'(exp0_q.size()), 64'd0);
      check("drain1", 64'(exp1_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
